spi_cmd_sequencer: RTL

SPI_CMD_SEQUENCER -- requirements
Module: spi_cmd_sequencer

---
 rtl/spi_pkg.sv | 6 +
 rtl/spi_cmd_sequencer_if.sv | 17 +
 rtl/spi_cmd_fifo.sv | 40 ++++
 rtl/spi_cmd_sequencer.sv | 76 +++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and default word geometry for the SPI command sequencer
package spi_pkg;
  localparam int DEF_REG_WIDTH = 8;
  localparam int DEF_MSG_LEN = 2;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} spi_seq_state_t;
endpackage

// File: rtl/spi_cmd_sequencer_if.sv
// spi_cmd_sequencer_if: host command and response channels of the SPI command sequencer
interface spi_cmd_sequencer_if #(parameter int REG_WIDTH = 8, parameter int MSG_LEN = 2);
  localparam int DW = REG_WIDTH * (MSG_LEN - 1);
  logic cmd_valid;
  logic cmd_ready;
  logic [REG_WIDTH-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic rsp_valid;
  logic rsp_ready;
  logic [REG_WIDTH-1:0] rsp_addr;
  logic [DW-1:0] rsp_data;
  logic rsp_err;
  modport master (output cmd_valid, cmd_addr, cmd_data, rsp_ready,
                  input cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_err);
  modport slave (input cmd_valid, cmd_addr, cmd_data, rsp_ready,
                 output cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_err);
endinterface

// File: rtl/spi_cmd_fifo.sv
// spi_cmd_fifo: synchronous command FIFO with occupancy count; pushes while full are dropped
module spi_cmd_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rstn,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [AW:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rptr];
  // pointers are exactly log2(DEPTH) bits, so they wrap on their own
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop) rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end
endmodule

// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: queues host register commands and issues them one at a time to an SPI writer
module spi_cmd_sequencer import spi_pkg::*; #(
  parameter int REG_WIDTH = DEF_REG_WIDTH,
  parameter int MSG_LEN = DEF_MSG_LEN,
  parameter int DEPTH = 8,
  parameter int TIMEOUT = 1024,
  localparam int DW = REG_WIDTH * (MSG_LEN - 1),
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int TW = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rstn,
  spi_cmd_sequencer_if.slave bus,
  output logic new_command,
  output logic [REG_WIDTH-1:0] register_addr,
  output logic [DW-1:0] write_data,
  input  logic transaction_complete,
  input  logic [DW-1:0] data_read_from_reg,
  output logic busy,
  output logic [CW-1:0] fifo_count,
  output logic timeout_err
);
  spi_seq_state_t state, state_nx;
  logic [TW-1:0] tcnt;
  logic [REG_WIDTH+DW-1:0] head;
  logic full, empty, pop, done, tout;
  spi_cmd_fifo #(.W(REG_WIDTH + DW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rstn(rstn),
    .push(bus.cmd_valid),
    .pop(pop),
    .din({bus.cmd_addr, bus.cmd_data}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(fifo_count)
  );
  assign bus.cmd_ready = !full;
  assign bus.rsp_valid = state == RESP;
  assign busy = state != IDLE || !empty;
  assign pop = state == IDLE && !empty;
  assign done = state == WAIT && transaction_complete;
  // completion wins when it lands on the last allowed WAIT cycle
  assign tout = state == WAIT && !transaction_complete && tcnt == TW'(TIMEOUT - 1);
  always_comb begin
    state_nx = state == IDLE  ? (empty ? IDLE : ISSUE) :
               state == ISSUE ? WAIT :
               state == WAIT  ? (done || tout ? RESP : WAIT) :
                                (bus.rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      tcnt <= '0;
      new_command <= 1'b0;
      register_addr <= '0;
      write_data <= '0;
      bus.rsp_addr <= '0;
      bus.rsp_data <= '0;
      bus.rsp_err <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      tcnt <= state == WAIT ? tcnt + TW'(1) : '0;
      if (pop) {register_addr, write_data} <= head;
      if (state == ISSUE) new_command <= 1'b1;
      if (done || tout) begin
        new_command <= 1'b0;
        bus.rsp_addr <= register_addr;
        bus.rsp_data <= done ? data_read_from_reg : '0;
        bus.rsp_err <= tout;
      end
      if (tout) timeout_err <= 1'b1;
    end
  end
endmodule
